// File: rtl/instr_encoder.sv
// instr_encoder
// Packs decoded-style instruction fields into 32-bit RV32I words and queues
// them in a 2-entry output FIFO. Each word is tagged with an auto-incrementing
// instruction-memory word address.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   addr_load/_val     reload the write address (blocks input that cycle)
//   enc_valid/ready    input field handshake
//   fmt, alu_op,
//   b_type, rd, rs1,
//   rs2, imm           fields to encode (decoder alu_op / branch funct3 codes)
//   out_valid/ready    output handshake on the FIFO head
//   out_instr/addr     encoded word and its word address
//   err, err_count     reject pulse and saturating reject counter
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        alu_op,
  input  logic [2:0]        b_type,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

  fifo_state_t state, state_next;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              is_shift;
  logic [4:0]        rd_f, rs1_f, rs2_f;
  logic              imm12_ok, imm13_ok, imm21_ok, shamt_ok;

  logic              accept, push, pop;
  logic              load_head, load_tail, shift_tail;
  logic [31:0]       head_instr, tail_instr;
  logic [ADDR_W-1:0] head_addr, tail_addr, wr_addr;

  assign rd_f  = {1'b0, rd};
  assign rs1_f = {1'b0, rs1};
  assign rs2_f = {1'b0, rs2};

  // Range checks: the upper bits must be pure sign extension of the field
  // that actually lands in the word; branch/jump offsets must also be even.
  assign imm12_ok = (imm[31:11] == {21{imm[31]}});
  assign imm13_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
  assign imm21_ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
  assign shamt_ok = (imm[31:5] == 27'd0);

  always_comb begin
    enc_word    = 32'h0;
    enc_illegal = 1'b0;
    funct3      = 3'b000;
    funct7      = 7'b0000000;
    is_shift    = 1'b0;
    case (fmt)
      3'd0: begin
        // Decoder R codes: ADD SUB XOR OR AND SLL SRL SRA SLT SLTU
        case (alu_op)
          5'd0: funct3 = 3'b000;
          5'd1: begin funct3 = 3'b000; funct7 = F7_ALT; end
          5'd2: funct3 = 3'b100;
          5'd3: funct3 = 3'b110;
          5'd4: funct3 = 3'b111;
          5'd5: funct3 = 3'b001;
          5'd6: funct3 = 3'b101;
          5'd7: begin funct3 = 3'b101; funct7 = F7_ALT; end
          5'd8: funct3 = 3'b010;
          5'd9: funct3 = 3'b011;
          default: enc_illegal = 1'b1;
        endcase
        enc_word = {funct7, rs2_f, rs1_f, funct3, rd_f, OP_R};
      end
      3'd1: begin
        // Decoder I codes: ADDI XORI ORI ANDI SLLI SRLI SRAI SLTI SLTIU
        case (alu_op)
          5'd10: funct3 = 3'b000;
          5'd11: funct3 = 3'b100;
          5'd12: funct3 = 3'b110;
          5'd13: funct3 = 3'b111;
          5'd14: begin funct3 = 3'b001; is_shift = 1'b1; end
          5'd15: begin funct3 = 3'b101; is_shift = 1'b1; end
          5'd16: begin funct3 = 3'b101; is_shift = 1'b1; funct7 = F7_ALT; end
          5'd17: funct3 = 3'b010;
          5'd18: funct3 = 3'b011;
          default: enc_illegal = 1'b1;
        endcase
        if (is_shift) begin
          if (!shamt_ok) enc_illegal = 1'b1;
          enc_word = {funct7, imm[4:0], rs1_f, funct3, rd_f, OP_I};
        end else begin
          if (!imm12_ok) enc_illegal = 1'b1;
          enc_word = {imm[11:0], rs1_f, funct3, rd_f, OP_I};
        end
      end
      3'd2: begin
        if (!imm13_ok) enc_illegal = 1'b1;
        enc_word = {imm[12], imm[10:5], rs2_f, rs1_f, b_type, imm[4:1], imm[11], OP_B};
      end
      3'd3: begin
        if (!imm21_ok) enc_illegal = 1'b1;
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd_f, OP_JAL};
      end
      3'd4: begin
        if (!imm12_ok) enc_illegal = 1'b1;
        enc_word = {imm[11:0], rs1_f, 3'b000, rd_f, OP_JALR};
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  // Input readiness looks only at occupancy, never at out_ready, so a full
  // FIFO stalls input for the cycle it pops.
  assign enc_ready = (state != FULL) && !addr_load;
  assign accept    = enc_valid && enc_ready;
  assign push      = accept && !enc_illegal;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:  if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // The head register drives the outputs directly; the tail only fills when
  // the head is occupied and not leaving this cycle.
  assign load_head  = push && ((state == EMPTY) || ((state == ONE) && pop));
  assign load_tail  = push && (state == ONE) && !pop;
  assign shift_tail = pop && (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_instr <= 32'h0;
      head_addr  <= '0;
      tail_instr <= 32'h0;
      tail_addr  <= '0;
      wr_addr    <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      if (load_head) begin
        head_instr <= enc_word;
        head_addr  <= wr_addr;
      end else if (shift_tail) begin
        head_instr <= tail_instr;
        head_addr  <= tail_addr;
      end
      if (load_tail) begin
        tail_instr <= enc_word;
        tail_addr  <= wr_addr;
      end
      if (addr_load)  wr_addr <= addr_load_val;
      else if (push)  wr_addr <= wr_addr + ADDR_ONE;
      err <= accept && enc_illegal;
      if (accept && enc_illegal && (err_count != ERR_MAX))
        err_count <= err_count + ERR_ONE;
    end
  end

  assign out_instr = head_instr;
  assign out_addr  = head_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Self-checking bench for instr_encoder: directed scenarios for the encodings,
// FIFO stall, reject handling, address wrap and reset, followed by randomized
// traffic compared against an arithmetic reference model with a queue.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_load;
  logic [9:0]  addr_load_val;
  logic        enc_valid;
  logic        enc_ready;
  logic [2:0]  fmt;
  logic [4:0]  alu_op;
  logic [2:0]  b_type;
  logic [3:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic        err;
  logic [7:0]  err_count;

  int checks = 0;
  int fails  = 0;

  int r_f3 [10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
  int i_f3 [9]  = '{0, 4, 6, 7, 1, 5, 5, 2, 3};

  instr_encoder #(.ADDR_W(10), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .addr_load(addr_load), .addr_load_val(addr_load_val),
    .enc_valid(enc_valid), .enc_ready(enc_ready),
    .fmt(fmt), .alu_op(alu_op), .b_type(b_type),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference encoder written from the instruction-set rules using integer
  // arithmetic on the signed immediate.
  function automatic void model_encode(input logic [2:0] f, input logic [4:0] op,
                                       input logic [2:0] bt, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [31:0] im,
                                       output bit legal, output logic [31:0] w);
    longint v, u, acc, rdv, s1v, s2v, btv, f7, f3, k;
    v = longint'($signed(im));
    rdv = longint'(d); s1v = longint'(s1); s2v = longint'(s2); btv = longint'(bt);
    legal = 1'b1; acc = 0; f7 = 0; f3 = 0;
    case (f)
      3'd0: begin
        if (op > 5'd9) legal = 1'b0;
        else begin
          f3 = r_f3[op];
          f7 = (op == 5'd1 || op == 5'd7) ? 32 : 0;
          acc = (f7 << 25) + (s2v << 20) + (s1v << 15) + (f3 << 12) + (rdv << 7) + 51;
        end
      end
      3'd1: begin
        if (op < 5'd10 || op > 5'd18) legal = 1'b0;
        else begin
          k = longint'(op) - 10;
          f3 = i_f3[k];
          if (k >= 4 && k <= 6) begin
            if (v < 0 || v > 31) legal = 1'b0;
            f7 = (k == 6) ? 32 : 0;
            acc = (f7 << 25) + (v << 20) + (s1v << 15) + (f3 << 12) + (rdv << 7) + 19;
          end else begin
            if (v < -2048 || v > 2047) legal = 1'b0;
            acc = ((v & 'hFFF) << 20) + (s1v << 15) + (f3 << 12) + (rdv << 7) + 19;
          end
        end
      end
      3'd2: begin
        if (v < -4096 || v > 4094 || (v & 1) != 0) legal = 1'b0;
        u = v & 'h1FFF;
        acc = (((u >> 12) & 1) << 31) + (((u >> 5) & 63) << 25) + (s2v << 20) + (s1v << 15)
            + (btv << 12) + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7) + 99;
      end
      3'd3: begin
        if (v < -1048576 || v > 1048574 || (v & 1) != 0) legal = 1'b0;
        u = v & 'h1FFFFF;
        acc = (((u >> 20) & 1) << 31) + (((u >> 1) & 1023) << 21) + (((u >> 11) & 1) << 20)
            + (((u >> 12) & 255) << 12) + (rdv << 7) + 111;
      end
      3'd4: begin
        if (v < -2048 || v > 2047) legal = 1'b0;
        acc = ((v & 'hFFF) << 20) + (s1v << 15) + (rdv << 7) + 103;
      end
      default: legal = 1'b0;
    endcase
    w = acc[31:0];
  endfunction

  task automatic set_fields(input logic [2:0] f, input logic [4:0] op, input logic [2:0] bt,
                            input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [31:0] im);
    fmt = f; alu_op = op; b_type = bt; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic idle_inputs();
    enc_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; addr_load_val = 10'h0;
    set_fields(3'd0, 5'd0, 3'd0, 4'd0, 4'd0, 4'd0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_out_instr: got %h want 0", out_instr); end
    checks++; if (out_addr !== 10'h0) begin fails++; $display("[TB] FAIL reset_out_addr: got %h want 0", out_addr); end
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    checks++; if (err_count !== 8'h0) begin fails++; $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (enc_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_enc_ready: got %b want 1", enc_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    do_reset();
    set_fields(3'd0, 5'd0, 3'd0, 4'd1, 4'd2, 4'd3, 32'h0);
    enc_valid = 1'b1;
    #1;
    checks++; if (enc_ready !== 1'b1) begin fails++; $display("[TB] FAIL add_ready: got %b want 1", enc_ready); end
    @(negedge clk);
    enc_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL add_latency: got out_valid %b want 1", out_valid); end
    checks++; if (out_instr !== 32'h003100B3) begin fails++; $display("[TB] FAIL add_instr: got %h want 003100b3", out_instr); end
    checks++; if (out_addr !== 10'h0) begin fails++; $display("[TB] FAIL add_addr: got %h want 0", out_addr); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL add_pop: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    set_fields(3'd1, 5'd10, 3'd0, 4'd5, 4'd0, 4'd0, 32'hFFFF_FFFF);
    enc_valid = 1'b1;
    @(negedge clk);
    set_fields(3'd0, 5'd1, 3'd0, 4'd3, 4'd1, 4'd2, 32'h0);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFFF00293 || out_addr !== 10'h0)
      begin fails++; $display("[TB] FAIL b2b_first: got v=%b %h @%h want v=1 fff00293 @000", out_valid, out_instr, out_addr); end
    @(negedge clk);
    enc_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h402081B3 || out_addr !== 10'h1)
      begin fails++; $display("[TB] FAIL b2b_second: got v=%b %h @%h want v=1 402081b3 @001", out_valid, out_instr, out_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_drain: got out_valid %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_formats();
    logic [2:0]  f_t   [4] = '{3'd2, 3'd3, 3'd1, 3'd4};
    logic [4:0]  op_t  [4] = '{5'd0, 5'd0, 5'd16, 5'd0};
    logic [3:0]  rd_t  [4] = '{4'd0, 4'd1, 4'd4, 4'd1};
    logic [3:0]  s1_t  [4] = '{4'd1, 4'd0, 4'd4, 4'd2};
    logic [3:0]  s2_t  [4] = '{4'd2, 4'd0, 4'd0, 4'd0};
    logic [31:0] im_t  [4] = '{32'd8, 32'd16, 32'd3, 32'hFFFF_FFFC};
    logic [31:0] exp_t [4] = '{32'h00208463, 32'h010000EF, 32'h40325213, 32'hFFC100E7};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(f_t[i], op_t[i], 3'd0, rd_t[i], s1_t[i], s2_t[i], im_t[i]);
      enc_valid = 1'b1;
      @(negedge clk);
      enc_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_instr !== exp_t[i] || out_addr !== 10'(i))
        begin fails++; $display("[TB] FAIL format_%0d: got v=%b %h @%h want v=1 %h @%h", i, out_valid, out_instr, out_addr, exp_t[i], 10'(i)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    do_reset();
    set_fields(3'd0, 5'd0, 3'd0, 4'd1, 4'd2, 4'd3, 32'h0);
    enc_valid = 1'b1;
    #1;
    checks++; if (enc_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_ready0: got %b want 1", enc_ready); end
    @(negedge clk);
    rd = 4'd2;
    #1;
    checks++; if (enc_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_ready1: got %b want 1", enc_ready); end
    @(negedge clk);
    rd = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (enc_ready !== 1'b0 || out_instr !== 32'h003100B3 || out_addr !== 10'h0)
        begin fails++; $display("[TB] FAIL stall_hold: got rdy=%b %h @%h want rdy=0 003100b3 @000", enc_ready, out_instr, out_addr); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_instr !== 32'h00310133 || out_addr !== 10'h1 || enc_ready !== 1'b1)
      begin fails++; $display("[TB] FAIL stall_pop1: got %h @%h rdy=%b want 00310133 @001 rdy=1", out_instr, out_addr, enc_ready); end
    @(negedge clk);
    enc_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h003101B3 || out_addr !== 10'h2)
      begin fails++; $display("[TB] FAIL stall_pop2: got v=%b %h @%h want v=1 003101b3 @002", out_valid, out_instr, out_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_drain: got out_valid %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    set_fields(3'd1, 5'd10, 3'd0, 4'd1, 4'd1, 4'd0, 32'd2048);
    enc_valid = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL err_addi: got err %b want 1", err); end
    set_fields(3'd2, 5'd0, 3'd0, 4'd0, 4'd1, 4'd2, 32'd7);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL err_beq: got err %b want 1", err); end
    set_fields(3'd6, 5'd0, 3'd0, 4'd1, 4'd1, 4'd1, 32'd0);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL err_fmt: got err %b want 1", err); end
    enc_valid = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || err_count !== 8'd3 || out_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL err_summary: got err=%b cnt=%0d v=%b want 0 3 0", err, err_count, out_valid); end
    set_fields(3'd0, 5'd0, 3'd0, 4'd1, 4'd2, 4'd3, 32'h0);
    enc_valid = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_addr !== 10'h0 || err !== 1'b0)
      begin fails++; $display("[TB] FAIL err_next_legal: got v=%b @%h err=%b want v=1 @000 err=0", out_valid, out_addr, err); end
  endtask

  task automatic test_err_saturation();
    do_reset();
    set_fields(3'd7, 5'd0, 3'd0, 4'd0, 4'd0, 4'd0, 32'h0);
    enc_valid = 1'b1;
    repeat (254) @(negedge clk);
    checks++; if (err_count !== 8'd254) begin fails++; $display("[TB] FAIL sat_254: got %0d want 254", err_count); end
    repeat (6) @(negedge clk);
    enc_valid = 1'b0;
    @(negedge clk);
    checks++; if (err_count !== 8'd255 || out_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL sat_255: got cnt=%0d v=%b want 255 0", err_count, out_valid); end
  endtask

  task automatic test_addr_wrap_reset();
    do_reset();
    set_fields(3'd0, 5'd0, 3'd0, 4'd1, 4'd2, 4'd3, 32'h0);
    addr_load = 1'b1;
    addr_load_val = 10'h3FF;
    enc_valid = 1'b1;
    #1;
    checks++; if (enc_ready !== 1'b0) begin fails++; $display("[TB] FAIL load_blocks_ready: got %b want 0", enc_ready); end
    @(negedge clk);
    addr_load = 1'b0;
    @(negedge clk);
    rd = 4'd2;
    checks++; if (out_instr !== 32'h003100B3 || out_addr !== 10'h3FF)
      begin fails++; $display("[TB] FAIL wrap_first: got %h @%h want 003100b3 @3ff", out_instr, out_addr); end
    @(negedge clk);
    enc_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_instr !== 32'h00310133 || out_addr !== 10'h000)
      begin fails++; $display("[TB] FAIL wrap_second: got %h @%h want 00310133 @000", out_instr, out_addr); end
    rd = 4'd3;
    enc_valid = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_addr !== 10'h0 || out_instr !== 32'h0)
      begin fails++; $display("[TB] FAIL midstream_reset: got v=%b %h @%h want v=0 0 @000", out_valid, out_instr, out_addr); end
    rd = 4'd1;
    enc_valid = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h003100B3 || out_addr !== 10'h0)
      begin fails++; $display("[TB] FAIL post_reset_word: got v=%b %h @%h want v=1 003100b3 @000", out_valid, out_instr, out_addr); end
  endtask

  task automatic test_random();
    logic [31:0] q_instr [$];
    logic [9:0]  q_addr  [$];
    logic [9:0]  m_addr;
    logic [7:0]  m_cnt;
    logic        m_err;
    logic [31:0] w;
    bit          legal, acc, pop_now, exp_rdy;
    int          sel;
    int          bnd [17] = '{-2049, -2048, 2047, 2048, 31, 32, -1, 0, -4096, -4098,
                              4094, 4096, -1048576, 1048574, 1048576, -1048578, 7};
    do_reset();
    m_addr = 10'h0; m_cnt = 8'h0; m_err = 1'b0;
    for (int it = 0; it < 500; it++) begin
      checks++; if (out_valid !== (q_instr.size() > 0))
        begin fails++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", it, out_valid, q_instr.size() > 0); end
      if (q_instr.size() > 0) begin
        checks++; if (out_instr !== q_instr[0] || out_addr !== q_addr[0])
          begin fails++; $display("[TB] FAIL rnd_head[%0d]: got %h @%h want %h @%h", it, out_instr, out_addr, q_instr[0], q_addr[0]); end
      end
      checks++; if (err !== m_err || err_count !== m_cnt)
        begin fails++; $display("[TB] FAIL rnd_err[%0d]: got err=%b cnt=%0d want err=%b cnt=%0d", it, err, err_count, m_err, m_cnt); end

      addr_load     = ($urandom_range(0, 15) == 0);
      addr_load_val = 10'($urandom);
      enc_valid     = ($urandom_range(0, 3) != 0);
      out_ready     = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      fmt = (sel < 2) ? 3'd0 : (sel < 5) ? 3'd1 : (sel == 5) ? 3'd2 : (sel == 6) ? 3'd3 :
            (sel == 7) ? 3'd4 : (sel == 8) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) alu_op = 5'($urandom_range(0, 31));
      else if (fmt == 3'd0)          alu_op = 5'($urandom_range(0, 9));
      else                           alu_op = 5'($urandom_range(10, 18));
      b_type = 3'($urandom); rd = 4'($urandom); rs1 = 4'($urandom); rs2 = 4'($urandom);
      case ($urandom_range(0, 5))
        0: imm = 32'($signed($urandom_range(0, 80)) - 40);
        1: imm = 32'($urandom_range(0, 31));
        2: imm = 32'(bnd[$urandom_range(0, 16)]);
        3: imm = $urandom;
        4: imm = 32'(($signed($urandom_range(0, 8191)) - 4096) * 2);
        default: imm = 32'(($signed($urandom_range(0, 1048575)) - 524288) * 2);
      endcase
      #1;
      exp_rdy = (q_instr.size() < 2) && !addr_load;
      checks++; if (enc_ready !== exp_rdy)
        begin fails++; $display("[TB] FAIL rnd_ready[%0d]: got %b want %b", it, enc_ready, exp_rdy); end

      model_encode(fmt, alu_op, b_type, rd, rs1, rs2, imm, legal, w);
      acc     = enc_valid && exp_rdy;
      pop_now = out_ready && (q_instr.size() > 0);
      if (pop_now) begin
        void'(q_instr.pop_front());
        void'(q_addr.pop_front());
      end
      m_err = acc && !legal;
      if (m_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (acc && legal) begin
        q_instr.push_back(w);
        q_addr.push_back(m_addr);
        m_addr = m_addr + 10'd1;
      end
      if (addr_load) m_addr = addr_load_val;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_formats();
    test_full_stall();
    test_errors();
    test_err_saturation();
    test_addr_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Instruction encoder for the 4-bit-register RISC CPU. Packs decoded-style fields (format, alu_op, b_type, rd/rs1/rs2, imm) into 32-bit RV32I words, using the alu_op and b_type codes the CPU decoder emits. It buffers the words in a 2-entry output FIFO and tags each word with an auto-incrementing instruction-memory word address. It feeds the instruction-memory loader and the self-checking benches, so that encode followed by decode reproduces the original fields.

Parameters:
ADDR_W, 10, width of instruction-memory word address.
ERR_W, 8, width of saturating error counter.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  synchronous active-high reset.
addr_load  in  1  load write address, priority over encode.
addr_load_val  in  ADDR_W  new base word address.
enc_valid  in  1  input fields valid.
enc_ready  out  1  encoder can accept fields.
fmt  in  3  0=R, 1=I-ALU, 2=B, 3=JAL, 4=JALR, others illegal.
alu_op  in  5  decoder ALU code (R: 00000-01001, I: 01010-10010).
b_type  in  3  branch funct3, passed through.
rd, rs1, rs2  in  4 each  register indices; zero-extended to 5-bit fields.
imm  in  32  signed immediate, byte offset for B/JAL.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts head.
out_instr  out  32  encoded word.
out_addr  out  ADDR_W  word address of out_instr.
err  out  1  one-cycle pulse on rejected input.
err_count  out  ERR_W  saturating count of rejected inputs.

Behaviour:
- Reset: FIFO empty, out_valid=0, out_instr=0, out_addr=0, write address=0, err=0, err_count=0. A reset while the FIFO holds data drops both entries.
- Input handshake: a transfer happens when enc_valid and enc_ready are both high. enc_ready = (fifo_count<2) and not addr_load. enc_ready does not depend on out_ready in the same cycle, so a full FIFO stalls input even while it pops.
- Encoding is combinational on the accepted fields. A legal word is written into the FIFO at the accept edge. Latency is 1 cycle from accept to out_valid when the FIFO was empty.
- Output handshake: a pop happens when out_valid and out_ready are both high. out_instr and out_addr hold stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- FIFO states: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY: a push goes to ONE.
  - ONE: a push with no pop goes to FULL; a pop with no push goes to EMPTY; push and pop together stay in ONE.
  - FULL: a pop goes to ONE.
- Opcodes: R=0110011, I=0010011, B=1100011, JAL=1101111, JALR=1100111.
- R-type funct3/funct7 by alu_op:
  - ADD 000/0000000; SUB 000/0100000.
  - XOR 100; OR 110; AND 111; SLL 001.
  - SRL 101/0000000; SRA 101/0100000.
  - SLT 010; SLTU 011.
  - funct7=0 unless stated.
- I-type funct3 by alu_op: ADDI 000, XORI 100, ORI 110, ANDI 111, SLLI 001, SRLI/SRAI 101, SLTI 010, SLTIU 011.
  - Shift immediates: instr[24:20]=imm[4:0]; instr[31:25]=0100000 for SRAI, 0 otherwise.
- B-type: funct3=b_type. Bits {31,30:25,11:8,7} = imm{12,10:5,4:1,11}.
- JAL: instr[31:12] = imm{20,10:1,11,19:12}.
- JALR: funct3=000, instr[31:20]=imm[11:0].
- Illegal input. Any of the following rejects the input:
  - fmt > 4.
  - alu_op outside the range for R or I.
  - I/JALR imm outside -2048..2047 (imm[31:11] not all equal).
  - Shift imm outside 0..31.
  - B imm outside -4096..4094, or imm[0]=1.
  - JAL imm outside ±1 MiB, or imm[0]=1.
- On reject: the input is still accepted (handshake completes) and no word is pushed. err pulses for 1 cycle, err_count increments and saturates at all-ones, and the write address does not advance.
- Write address: each pushed word takes the current address, which then increments by 1 and wraps modulo 2^ADDR_W.
- addr_load: sets the write address for the next push. Entries already in the FIFO keep their addresses.

Test Plan:
- Reset, then R ADD rd=1 rs1=2 rs2=3 -> out_instr=0x003100B3, out_addr=0, out_valid 1 cycle after accept.
- I ADDI rd=5 rs1=0 imm=-1, then R SUB rd=3 rs1=1 rs2=2 back-to-back with out_ready=1 -> 0xFFF00293 @0, then 0x402081B3 @1, no bubbles.
- B b_type=000 rs1=1 rs2=2 imm=8 -> 0x00208463. JAL rd=1 imm=16 -> 0x010000EF. SRAI rd=4 rs1=4 imm=3 -> 0x40325213.
- out_ready=0 with three valid inputs -> enc_ready drops after 2 accepts and head is held stable. Raise out_ready -> words pop in order with consecutive addresses.
- ADDI imm=2048, BEQ imm=7, fmt=6 -> 3 err pulses, err_count=3, no out_valid, next legal word still at addr 0.
- addr_load_val=0x3FF, then 2 legal words -> out_addr 0x3FF then 0x000 (wrap). Assert rst mid-stream -> out_valid=0 next cycle, address 0.
